// File: rtl/seven_seg_pkg.sv
// Seven-segment display constants shared by the display encoder and the loop-back decoder.
package seven_seg_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         MAX_MAG   = 99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Maps one active-low seven-segment pattern back to its decimal digit.
module seven_seg_digit_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG_DIGIT[i]) begin
                digit = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_8bit_decoder.sv
// Glitch-filtered reconstruction of a signed two-digit value from the display segment lines.
module seven_seg_8bit_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [6:0] seg_high,
    input  logic [6:0] seg_low,
    input  logic       dp_high,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       code_err,
    output state_t     state_dbg
);

    // data_valid and code_err are single-cycle qualifiers with no back-pressure:
    // data_out is meaningful from the cycle data_valid is high until the next pulse.

    localparam logic [7:0]  STABLE_N  = 8'(STABLE_SAMPLES);
    localparam logic [14:0] RAW_RESET = {1'b1, SEG_BLANK, SEG_BLANK};

    logic [14:0] raw;
    logic [14:0] prev_raw;
    logic [7:0]  run_cnt;
    state_t      state;

    logic [3:0]  hi_digit, lo_digit;
    logic        hi_valid, lo_valid;
    logic [6:0]  mag;
    logic [7:0]  mag8;
    logic [7:0]  signed_val;
    logic        digits_ok;
    logic        same_raw;
    logic        do_restart, do_count, do_accept;

    assign raw       = {dp_high, seg_high, seg_low};
    assign same_raw  = (raw == prev_raw);
    assign state_dbg = state;

    seven_seg_digit_decode u_dec_high (
        .seg   (seg_high),
        .digit (hi_digit),
        .valid (hi_valid)
    );

    seven_seg_digit_decode u_dec_low (
        .seg   (seg_low),
        .digit (lo_digit),
        .valid (lo_valid)
    );

    assign mag        = 7'(hi_digit) * 7'd10 + 7'(lo_digit);
    assign mag8       = {1'b0, mag};
    assign digits_ok  = hi_valid && lo_valid && (mag <= 7'(MAX_MAG));
    // Negative zero folds naturally to 0 here
    assign signed_val = dp_high ? (8'd0 - mag8) : mag8;

    always_comb begin
        do_restart = 1'b0;
        do_count   = 1'b0;
        do_accept  = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE:   do_restart = 1'b1;
                TRACK: begin
                    if (!same_raw)
                        do_restart = 1'b1;
                    else if (run_cnt + 8'd1 >= STABLE_N)
                        do_accept = 1'b1;
                    else
                        do_count = 1'b1;
                end
                LOCKED: do_restart = !same_raw;
                default: do_restart = 1'b1;
            endcase
            // A one-sample filter accepts on the very sample that starts the run
            if (do_restart && STABLE_N == 8'd1)
                do_accept = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            run_cnt    <= 8'd0;
            prev_raw   <= RAW_RESET;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            if (do_restart) begin
                prev_raw <= raw;
                run_cnt  <= 8'd1;
                state    <= do_accept ? LOCKED : TRACK;
            end else if (do_accept) begin
                run_cnt <= STABLE_N;
                state   <= LOCKED;
            end else if (do_count) begin
                run_cnt <= run_cnt + 8'd1;
            end
            if (do_accept) begin
                if (digits_ok) begin
                    data_out   <= signed_val;
                    data_valid <= 1'b1;
                end else begin
                    code_err <= 1'b1;
                end
            end
        end
    end

endmodule
